dsp_mac_sequencer: RTL and testbench
====================================

// Module: dsp_mac_sequencer
// PURPOSE
//  Sequences one DSP48A1 slice as a multiply-accumulate engine for dot products.
//  Accepts a command (length N), streams N A/B operand pairs by valid/ready, and drives opmode/CE so P = sum(A*B).
//  Returns the 48-bit sum by valid/ready. Sits between the stream source and the DSP48A1 instance.
//  Targets the slice's default register set: A1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0.
// PARAMETERS
//  MLAT   2   cycles from A/B at DSP inputs to product valid at DSP M output (A1REG+MREG); must be >=1
//  CNT_W  10  width of length field and internal counters
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when valid&ready
//  cmd_len      in   CNT_W  number of products N (0 allowed)
//  in_valid     in   1      operand pair present
//  in_ready     out  1      operand pair accepted when valid&ready
//  in_a         in   18     multiplicand (unsigned)
//  in_b         in   18     multiplier (unsigned)
//  res_valid    out  1      result present
//  res_ready    in   1      result consumed when valid&ready
//  res_data     out  48     accumulated sum
//  dsp_a        out  18     to DSP A = in_a (combinational)
//  dsp_b        out  18     to DSP B = in_b (combinational)
//  dsp_opmode   out  8      to DSP opmode
//  dsp_ceP      out  1      to DSP ceP
//  dsp_rstP     out  1      to DSP rstP = rst
//  dsp_carryin  out  1      constant 0
//  dsp_p        in   48     from DSP P
// BEHAVIOUR
//  States: IDLE, STREAM, DRAIN, RESULT. Reset -> IDLE.
//  Reset values: cmd_ready=1; in_ready=0; res_valid=0; res_data=0; dsp_ceP=0; dsp_opmode=8'h09; tags/counters=0.
//  Tied-high DSP enables (ceA/ceB/ceM/ceopmode=1) are wired at top level, not driven here.
//  Tied-low DSP controls (other resets and opmode[7:4]=0: add, no pre-adder, CIN=0) are also wired at top level.
//  IDLE: cmd_ready=1. Command with N>0 -> STREAM; issue cnt=0. Command with N=0 -> RESULT with res_data=0; DSP untouched.
//  STREAM: in_ready=1 while cnt<N. Each accepted pair enters a MLAT+1 deep tag pipe {vld, first}; first=(cnt==0).
//  STREAM exit: accepting the Nth pair (cnt==N-1) -> DRAIN.
//  Bubbles (in_valid=0): vld=0 enters the pipe. A/B still propagate, but ceP stays low so P is unaffected.
//  Opmode: dsp_opmode = tag[MLAT-1].first ? 8'h01 (P=M) : 8'h09 (P=P+M).
//  Opmode alignment: the DSP opmode register lines this up with M.
//  ceP: dsp_ceP = tag[MLAT].vld. Accumulation occurs at edge ending cycle t+MLAT for a pair accepted in cycle t.
//  DRAIN: wait for the last tag. When tag[MLAT].vld and it is last, dsp_p holds the final sum next cycle.
//  DRAIN exit: capture dsp_p into res_data that cycle -> RESULT. Last pair accepted at t => res_valid at t+MLAT+2.
//  RESULT: res_valid=1; res_data stable until res_ready.
//  RESULT exit: on handshake -> IDLE; cmd_ready returns high the next cycle. No new command accepted while busy.
//  Arithmetic: 36-bit products, 48-bit wrap-around sum. No saturation. Overflow is silent.
//  Reset mid-operation: all state, tags and counters clear. rst also clears DSP P through dsp_rstP.
//  Reset mid-operation: any pending result is discarded; operands in flight are dropped.
//  Simultaneous cmd/in handshakes: in_ready is 0 in IDLE, so operands never pair with the command cycle.
// TESTING
//  Dot product: N=4; pairs (3,5),(2,7),(1,1),(10,10) back-to-back -> res_data=130; res_valid 4 cycles after last accept.
//  Bubbles: same N=4 with in_valid low 2 cycles between every pair -> res_data=130; dsp_ceP pulses exactly 4 times.
//  Full-scale: N=1, (0x3FFFF,0x3FFFF) -> res_data=48'h000F_FFF8_0001. First-product opmode seen = 8'h01.
//  Backpressure: res_ready low 10 cycles -> res_valid/res_data hold.
//  Backpressure: cmd_ready=0 and in_ready=0 throughout; second command accepted the cycle after handshake.
//  Second command: N=2 (4,4),(1,1) -> 17. No leakage from the prior sum.
//  N=0 and reset: N=0 -> res_data=0 with no dsp_ceP pulse.
//  N=0 and reset: rst asserted after 2 of 4 pairs -> IDLE, cmd_ready=1.
//  N=0 and reset: next N=1 (6,7) -> res_data=42.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequences a DSP48A1 slice as a dot-product MAC: accepts a length command,
// streams A/B pairs into the slice, and returns the accumulated P by valid/ready.
module dsp_mac_sequencer #(
  parameter int MLAT  = 2,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ceP,
  output logic             dsp_rstP,
  output logic             dsp_carryin,
  input  logic [47:0]      dsp_p
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;

  localparam logic [7:0] OPM_LOAD = 8'h01;  // P = M
  localparam logic [7:0] OPM_ACC  = 8'h09;  // P = P + M

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, len;
  logic             cap_pend;
  logic             in_fire, cmd_fire;

  // Tag pipe: stage 0 is the pair being accepted this cycle, stages 1..MLAT
  // follow the operands through the A1/M registers of the slice.
  logic [MLAT:1] vld_q, first_q, last_q;
  logic [MLAT:0] vld_pipe, first_pipe, last_pipe;

  assign in_fire    = in_valid & in_ready;
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign vld_pipe   = {vld_q, in_fire};
  assign first_pipe = {first_q, in_fire & (cnt == '0)};
  assign last_pipe  = {last_q, in_fire & (cnt == len - 1'b1)};

  assign dsp_a       = in_a;
  assign dsp_b       = in_b;
  assign dsp_rstP    = rst;
  assign dsp_carryin = 1'b0;
  // The slice's opmode register delays this by one cycle, lining it up with M.
  assign dsp_opmode  = first_pipe[MLAT-1] ? OPM_LOAD : OPM_ACC;
  assign dsp_ceP     = vld_pipe[MLAT];

  // NOTE: every output and next-state gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == '0) ? RESULT : STREAM;
      end
      STREAM: begin
        in_ready = (cnt < len);
        if (in_valid && in_ready && (cnt == len - 1'b1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cap_pend) state_nxt = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      vld_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      cap_pend <= 1'b0;
      res_data <= '0;
    end else begin
      state   <= state_nxt;
      vld_q   <= vld_pipe[MLAT-1:0];
      first_q <= first_pipe[MLAT-1:0];
      last_q  <= last_pipe[MLAT-1:0];
      // P holds the final sum the cycle after the last tag enables ceP.
      cap_pend <= vld_pipe[MLAT] & last_pipe[MLAT];

      if (cmd_fire) begin
        cnt <= '0;
        len <= cmd_len;
        if (cmd_len == '0) res_data <= '0;
      end else if (in_fire) begin
        cnt <= cnt + 1'b1;
      end

      if (state == DRAIN && cap_pend) res_data <= dsp_p;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer with a behavioural DSP48A1 model
// (A1REG, MREG, OPMODEREG, PREG) closing the loop on dsp_p.
module tb_dsp_mac_sequencer;
  localparam int CNT_W = 10;
  localparam int MLAT  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic             in_valid, in_ready;
  logic [17:0]      in_a, in_b;
  logic             res_valid, res_ready;
  logic [47:0]      res_data;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ceP, dsp_rstP, dsp_carryin;
  logic [47:0]      dsp_p;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.MLAT(MLAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_ceP(dsp_ceP), .dsp_rstP(dsp_rstP), .dsp_carryin(dsp_carryin),
    .dsp_p(dsp_p)
  );

  // DSP48A1 model: Z mux from opmode[3:2] (10 = P), X mux from opmode[1:0] (01 = M).
  logic [17:0] a1_q, b1_q;
  logic [35:0] m_q;
  logic [7:0]  opm_q = 8'h00;
  logic [47:0] p_q = '0;
  always @(posedge clk) begin
    a1_q  <= dsp_a;
    b1_q  <= dsp_b;
    m_q   <= a1_q * b1_q;
    opm_q <= dsp_opmode;
    if (dsp_rstP) p_q <= '0;
    else if (dsp_ceP)
      p_q <= ((opm_q[3:2] == 2'b10) ? p_q : 48'd0) +
             ((opm_q[1:0] == 2'b01) ? {12'd0, m_q} : 48'd0);
  end
  assign dsp_p = p_q;

  int         cyc = 0;
  int         cep_cnt = 0;
  logic [7:0] cep_opm = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dsp_ceP) begin
      cep_cnt <= cep_cnt + 1;
      cep_opm <= opm_q;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int               len;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    int               gap;
    int               hold;
    logic [47:0]      exp;
  } vec_t;

  function automatic vec_t mk(input int len,
                              input logic [17:0] a0, b0, a1, b1, a2, b2, a3, b3,
                              input int gap, input int hold, input logic [47:0] exp);
    vec_t v;
    v.len = len;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.gap = gap; v.hold = hold; v.exp = exp;
    return v;
  endfunction

  // Runs one command through to result handshake, starting at a negedge.
  task automatic run_vec(input vec_t v, input string tag);
    int c0;
    int acc_cyc;
    int t;
    c0 = cep_cnt;
    acc_cyc = 0;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    check({tag, ".cmd_ready"}, {47'd0, cmd_ready}, 48'd1);
    cmd_valid = 1'b1;
    cmd_len   = CNT_W'(v.len);
    @(negedge clk);
    cmd_valid = 1'b0;

    for (int i = 0; i < v.len; i++) begin
      repeat (v.gap) @(negedge clk);
      in_valid = 1'b1;
      in_a = v.a[i];
      in_b = v.b[i];
      t = 0;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
    end

    t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    check({tag, ".res_valid"}, {47'd0, res_valid}, 48'd1);
    if (v.len > 0) check({tag, ".latency"}, 48'(cyc - acc_cyc), 48'd3);
    check({tag, ".res_data"}, res_data, v.exp);

    for (int h = 0; h < v.hold; h++) begin
      check({tag, ".hold_valid"}, {47'd0, res_valid}, 48'd1);
      check({tag, ".hold_data"}, res_data, v.exp);
      check({tag, ".busy_ready"}, {46'd0, cmd_ready, in_ready}, 48'd0);
      @(negedge clk);
    end

    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ".cmd_ready_after"}, {47'd0, cmd_ready}, 48'd1);
    check({tag, ".res_valid_after"}, {47'd0, res_valid}, 48'd0);
    check({tag, ".cep_pulses"}, 48'(cep_cnt - c0), 48'(v.len));
    if (v.len > 0)
      check({tag, ".last_opmode"}, {40'd0, cep_opm}, (v.len == 1) ? 48'h01 : 48'h09);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(4, 3, 5, 2, 7, 1, 1, 10, 10, 0, 0, 48'd130);
    vecs[1] = mk(4, 3, 5, 2, 7, 1, 1, 10, 10, 2, 0, 48'd130);
    vecs[2] = mk(1, 18'h3FFFF, 18'h3FFFF, 0, 0, 0, 0, 0, 0, 0, 10, 48'h000F_FFF8_0001);
    vecs[3] = mk(2, 4, 4, 1, 1, 0, 0, 0, 0, 0, 0, 48'd17);
    vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 48'd0);
    vecs[5] = mk(3, 100, 200, 0, 5, 7, 9, 0, 0, 1, 3, 48'd20063);

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_len = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.rstP", {47'd0, dsp_rstP}, 48'd1);
    rst = 1'b0;
    @(negedge clk);
    check("reset.cmd_ready", {47'd0, cmd_ready}, 48'd1);
    check("reset.in_ready", {47'd0, in_ready}, 48'd0);
    check("reset.res_valid", {47'd0, res_valid}, 48'd0);
    check("reset.res_data", res_data, 48'd0);
    check("reset.ceP", {47'd0, dsp_ceP}, 48'd0);
    check("reset.opmode", {40'd0, dsp_opmode}, 48'h09);
    check("reset.carryin", {47'd0, dsp_carryin}, 48'd0);
    check("reset.rstP_low", {47'd0, dsp_rstP}, 48'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a 4-pair command after two pairs.
    cmd_valid = 1'b1; cmd_len = CNT_W'(4);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 18'(9 + i); in_b = 18'd3;
      check("midrst.in_ready", {47'd0, in_ready}, 48'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.cmd_ready", {47'd0, cmd_ready}, 48'd1);
    check("midrst.in_ready_low", {47'd0, in_ready}, 48'd0);
    check("midrst.res_valid", {47'd0, res_valid}, 48'd0);
    check("midrst.res_data", res_data, 48'd0);
    check("midrst.ceP", {47'd0, dsp_ceP}, 48'd0);
    run_vec(mk(1, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 48'd42), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
